// File: rtl/multicycle_control_unit.sv
// Multi-cycle main control FSM: fetch/decode/execute/memory/writeback sequencing
// with req/ready handshakes, wait timeout and traps. Optional macro: PERF_CNT_EN.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 7,
  parameter int ALU_OP_W    = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                halt,
  input  logic                if_ready,
  input  logic                mem_ready,
  input  logic                trap_clr,
  output logic                if_req,
  output logic                ir_w,
  output logic                pc_w,
  output logic [ALU_OP_W-1:0] ctrl_ALU_op,
  output logic                ctrl_ALU_src_a,
  output logic [1:0]          ctrl_ALU_src_b,
  output logic                ctrl_reg_w,
  output logic                ctrl_mem_w,
  output logic                ctrl_mem_r,
  output logic                ctrl_mem_to_reg,
  output logic                ctrl_branch,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    instret
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_LOAD, C_STORE, C_ARITH, C_ARITH_I, C_BRANCH
  } cls_t;

  localparam logic [OPCODE_W-1:0] OP_LOAD    = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE   = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_ARITH   = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_ARITH_I = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_BRANCH  = OPCODE_W'(7'b1100011);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_FETCH   = 2'b10;
  localparam logic [1:0] CAUSE_DATA    = 2'b11;

  state_t     state, state_next;
  cls_t       cls, dec_cls;
  logic       dec_legal;
  logic [1:0] cause_next;
  logic [7:0] wait_cnt;
  logic       wait_done;

  // The ready input arriving in this cycle would push the count to MEM_TIMEOUT.
  assign wait_done = (wait_cnt == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    dec_cls   = C_ARITH;
    dec_legal = 1'b1;
    case (opcode)
      OP_LOAD:    dec_cls = C_LOAD;
      OP_STORE:   dec_cls = C_STORE;
      OP_ARITH:   dec_cls = C_ARITH;
      OP_ARITH_I: dec_cls = C_ARITH_I;
      OP_BRANCH:  dec_cls = C_BRANCH;
      default:    dec_legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cls        <= C_ARITH;
      wait_cnt   <= '0;
      trap_cause <= 2'b00;
    end else begin
      state <= state_next;
      if (state == S_DECODE && dec_legal)
        cls <= dec_cls;
      if ((state == S_FETCH || state == S_MEM) && state_next == state)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;
      if (state != S_TRAP && state_next == S_TRAP)
        trap_cause <= cause_next;
      else if (state == S_TRAP && trap_clr)
        trap_cause <= 2'b00;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cause_next = 2'b00;
    case (state)
      S_IDLE:   if (!halt) state_next = S_FETCH;
      S_FETCH: begin
        if (if_ready)       state_next = S_DECODE;
        else if (halt)      state_next = S_IDLE;
        else if (wait_done) begin
          state_next = S_TRAP;
          cause_next = CAUSE_FETCH;
        end
      end
      S_DECODE: begin
        if (dec_legal) state_next = S_EXEC;
        else begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE:   state_next = S_MEM;
          C_ARITH, C_ARITH_I: state_next = S_WB;
          default:           state_next = halt ? S_IDLE : S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (cls == C_LOAD) state_next = S_WB;
          else               state_next = halt ? S_IDLE : S_FETCH;
        end else if (wait_done) begin
          state_next = S_TRAP;
          cause_next = CAUSE_DATA;
        end
      end
      S_WB:     state_next = halt ? S_IDLE : S_FETCH;
      S_TRAP:   if (trap_clr) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    if_req          = 1'b0;
    ir_w            = 1'b0;
    pc_w            = 1'b0;
    ctrl_ALU_op     = '0;
    ctrl_ALU_src_a  = 1'b0;
    ctrl_ALU_src_b  = 2'b00;
    ctrl_reg_w      = 1'b0;
    ctrl_mem_w      = 1'b0;
    ctrl_mem_r      = 1'b0;
    ctrl_mem_to_reg = 1'b0;
    ctrl_branch     = 1'b0;
    trap            = 1'b0;
    case (state)
      S_FETCH: begin
        // IR and PC must load in the ack cycle itself, so these two strobes
        // are qualified by if_ready rather than waiting a cycle.
        if_req         = 1'b1;
        ir_w           = if_ready;
        pc_w           = if_ready;
        ctrl_ALU_src_a = 1'b1;
        ctrl_ALU_src_b = 2'b01;
      end
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: ctrl_ALU_src_b = 2'b10;
          C_ARITH:   ctrl_ALU_op = ALU_OP_W'(2'b10);
          C_ARITH_I: begin
            ctrl_ALU_op    = ALU_OP_W'(2'b11);
            ctrl_ALU_src_b = 2'b10;
          end
          default: begin
            ctrl_ALU_op = ALU_OP_W'(2'b01);
            ctrl_branch = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        ctrl_mem_r = (cls == C_LOAD);
        ctrl_mem_w = (cls == C_STORE);
      end
      S_WB: begin
        ctrl_reg_w      = 1'b1;
        ctrl_mem_to_reg = (cls == C_LOAD);
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

`ifdef PERF_CNT_EN
  logic retire;
  assign retire = (state == S_WB) ||
                  (state == S_EXEC && cls == C_BRANCH) ||
                  (state == S_MEM && cls == C_STORE && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + 1'b1;
  end
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-instruction table, corner
// sequences and randomized instructions against a transaction-level model.
module tb_multicycle_control_unit;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst_n, halt, if_ready, mem_ready, trap_clr;
  logic [6:0]  opcode;
  logic        if_req, ir_w, pc_w, ctrl_ALU_src_a, ctrl_reg_w, ctrl_mem_w;
  logic        ctrl_mem_r, ctrl_mem_to_reg, ctrl_branch, trap;
  logic [1:0]  ctrl_ALU_op, ctrl_ALU_src_b, trap_cause;
  logic [31:0] instret;
  logic        any_out;

  int vectors = 0;
  int miscompares = 0;
  int exp_instret = 0;

  multicycle_control_unit #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .halt(halt),
    .if_ready(if_ready), .mem_ready(mem_ready), .trap_clr(trap_clr),
    .if_req(if_req), .ir_w(ir_w), .pc_w(pc_w), .ctrl_ALU_op(ctrl_ALU_op),
    .ctrl_ALU_src_a(ctrl_ALU_src_a), .ctrl_ALU_src_b(ctrl_ALU_src_b),
    .ctrl_reg_w(ctrl_reg_w), .ctrl_mem_w(ctrl_mem_w), .ctrl_mem_r(ctrl_mem_r),
    .ctrl_mem_to_reg(ctrl_mem_to_reg), .ctrl_branch(ctrl_branch),
    .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  assign any_out = |{if_req, ir_w, pc_w, ctrl_ALU_op, ctrl_ALU_src_a, ctrl_ALU_src_b,
                     ctrl_reg_w, ctrl_mem_w, ctrl_mem_r, ctrl_mem_to_reg,
                     ctrl_branch, trap, trap_cause};

  typedef struct {
    int total, n_if_req, n_src_a, n_ir_w, n_pc_w, n_mem_r, n_mem_w;
    int n_reg_w, n_m2r, n_branch, trap, cause, alu_op, src_b, retired;
  } stats_t;

  typedef struct {
    logic [6:0] op;
    int fw, mw;
    int total, n_mem, reg_w, branch, trap, cause;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef PERF_CNT_EN
    return exp_instret;
`else
    return 32'd0;
`endif
  endfunction

  task automatic cyc(input logic h, input logic ir, input logic mr, input logic tc);
    @(negedge clk);
    halt = h; if_ready = ir; mem_ready = mr; trap_clr = tc;
    #1;
  endtask

  // Instruction outcome derived from the cycle rules: fetch waits fw cycles,
  // a memory access waits mw cycles, a wait of T or more cycles traps.
  function automatic stats_t model(input logic [6:0] op, input int fw, input int mw);
    stats_t m = '{default: 0};
    int t;
    if (fw >= T) begin
      m.n_if_req = T; m.n_src_a = T; m.total = T + 1; m.trap = 1; m.cause = 2;
      return m;
    end
    m.n_if_req = fw + 1; m.n_src_a = fw + 1; m.n_ir_w = 1; m.n_pc_w = 1;
    t = fw + 3;
    case (op)
      7'b0110011: begin m.alu_op = 2; m.total = t + 1; m.n_reg_w = 1; m.retired = 1; end
      7'b0010011: begin m.alu_op = 3; m.src_b = 2; m.total = t + 1; m.n_reg_w = 1; m.retired = 1; end
      7'b1100011: begin m.alu_op = 1; m.total = t; m.n_branch = 1; m.retired = 1; end
      7'b0000011, 7'b0100011: begin
        m.src_b = 2;
        if (mw >= T) begin
          m.total = t + T + 1; m.trap = 1; m.cause = 3;
          if (op == 7'b0000011) m.n_mem_r = T; else m.n_mem_w = T;
        end else if (op == 7'b0000011) begin
          m.n_mem_r = mw + 1; m.total = t + mw + 2; m.n_reg_w = 1; m.n_m2r = 1; m.retired = 1;
        end else begin
          m.n_mem_w = mw + 1; m.total = t + mw + 1; m.retired = 1;
        end
      end
      default: begin m.total = fw + 3; m.trap = 1; m.cause = 1; end
    endcase
    return m;
  endfunction

  // Runs one instruction starting in its first fetch cycle; a trap is cleared
  // afterwards so the next call again starts in FETCH.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, output stats_t s);
    int nf, nm, kir;
    bit done;
    s = '{default: 0};
    nf = 0; nm = 0; kir = -1; done = 0;
    opcode = op;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      halt = 1'b0; trap_clr = 1'b0;
      if_ready  = if_req ? (nf == fw) : 1'($urandom_range(0, 1));
      mem_ready = (ctrl_mem_r | ctrl_mem_w) ? (nm == mw) : 1'($urandom_range(0, 1));
      #1;
      s.total++;
      if (if_req) nf++;
      if (ctrl_mem_r | ctrl_mem_w) nm++;
      s.n_if_req += int'(if_req);       s.n_src_a += int'(ctrl_ALU_src_a);
      s.n_ir_w   += int'(ir_w);         s.n_pc_w  += int'(pc_w);
      s.n_mem_r  += int'(ctrl_mem_r);   s.n_mem_w += int'(ctrl_mem_w);
      s.n_reg_w  += int'(ctrl_reg_w);   s.n_m2r   += int'(ctrl_mem_to_reg);
      s.n_branch += int'(ctrl_branch);
      if (ir_w) kir = k;
      if (kir >= 0 && k == kir + 2) begin
        s.alu_op = int'(ctrl_ALU_op);
        s.src_b  = int'(ctrl_ALU_src_b);
      end
      if (ctrl_reg_w || ctrl_branch || (ctrl_mem_w && mem_ready) || trap) begin
        done = 1;
        s.trap = int'(trap);
        s.cause = int'(trap_cause);
      end
    end
    if (!done) check("run_bound", 32'd0, 32'd1);
    if (s.trap != 0) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("clr_trap", 32'(trap), 32'd0);
      check("clr_cause", 32'(trap_cause), 32'd0);
      check("clr_if_req", 32'(if_req), 32'd0);
    end
  endtask

  task automatic compare_all(input string tag, input stats_t s, input stats_t m);
    check({tag, "_total"},  s.total,    m.total);
    check({tag, "_if_req"}, s.n_if_req, m.n_if_req);
    check({tag, "_src_a"},  s.n_src_a,  m.n_src_a);
    check({tag, "_ir_w"},   s.n_ir_w,   m.n_ir_w);
    check({tag, "_pc_w"},   s.n_pc_w,   m.n_pc_w);
    check({tag, "_mem_r"},  s.n_mem_r,  m.n_mem_r);
    check({tag, "_mem_w"},  s.n_mem_w,  m.n_mem_w);
    check({tag, "_reg_w"},  s.n_reg_w,  m.n_reg_w);
    check({tag, "_m2r"},    s.n_m2r,    m.n_m2r);
    check({tag, "_branch"}, s.n_branch, m.n_branch);
    check({tag, "_trap"},   s.trap,     m.trap);
    check({tag, "_cause"},  s.cause,    m.cause);
    check({tag, "_alu_op"}, s.alu_op,   m.alu_op);
    check({tag, "_src_b"},  s.src_b,    m.src_b);
  endtask

  task automatic check_instret(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_instret"}, instret, exp_count());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[9];
    stats_t     s, m;
    logic [6:0] ops[5];
    logic [6:0] op;
    int         fw, mw;

    tbl[0] = '{7'b0110011, 0,  0,  4,  0, 1, 0, 0, 0};
    tbl[1] = '{7'b0000011, 0,  3,  8,  4, 1, 0, 0, 0};
    tbl[2] = '{7'b0100011, 0, 15, 19, 15, 0, 0, 1, 3};
    tbl[3] = '{7'b1111111, 0,  0,  3,  0, 0, 0, 1, 1};
    tbl[4] = '{7'b1100011, 2,  0,  5,  0, 0, 1, 0, 0};
    tbl[5] = '{7'b0010011, 14, 0, 18,  0, 1, 0, 0, 0};
    tbl[6] = '{7'b0110011, 15, 0, 16,  0, 0, 0, 1, 2};
    tbl[7] = '{7'b0100011, 1, 14, 19, 15, 0, 0, 0, 0};
    tbl[8] = '{7'b0000011, 0, 15, 19, 15, 0, 0, 1, 3};
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};

    rst_n = 1'b0; halt = 1'b0; if_ready = 1'b0; mem_ready = 1'b0;
    trap_clr = 1'b0; opcode = '0;
    #12;
    check("reset_outs", 32'(any_out), 32'd0);
    check("reset_instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_outs", 32'(any_out), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, s);
      check($sformatf("t%0d_total", i),  s.total, tbl[i].total);
      check($sformatf("t%0d_mem", i),    s.n_mem_r + s.n_mem_w, tbl[i].n_mem);
      check($sformatf("t%0d_reg_w", i),  s.n_reg_w, tbl[i].reg_w);
      check($sformatf("t%0d_branch", i), s.n_branch, tbl[i].branch);
      check($sformatf("t%0d_trap", i),   s.trap, tbl[i].trap);
      check($sformatf("t%0d_cause", i),  s.cause, tbl[i].cause);
      if (tbl[i].trap == 0) exp_instret++;
      check_instret($sformatf("t%0d", i));
    end

    // Branch with halt raised during EXEC parks in IDLE until halt drops.
    opcode = 7'b1100011;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("br_ir_w", 32'(ir_w), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("br_strobe", 32'(ctrl_branch), 32'd1);
    check("br_alu_op", 32'(ctrl_ALU_op), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("br_halt_idle", 32'(any_out), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("br_halt_hold", 32'(if_req), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("br_idle_exit", 32'(if_req), 32'd0);
    exp_instret++;
    check_instret("br");

    // Reset in the MEM step of a load, then a fetch aborted by halt.
    opcode = 7'b0000011;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_pre_mem_r", 32'(ctrl_mem_r), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outs", 32'(any_out), 32'd0);
    check("rst_async_instret", instret, 32'd0);
    exp_instret = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_idle", 32'(if_req), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_rel_fetch", 32'(if_req), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("fetch_halt_idle", 32'(if_req), 32'd0);
    check_instret("rst");

    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
      fw = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 1, T + 1) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 5) == 0) ? $urandom_range(T - 1, T + 1) : $urandom_range(0, 4);
      m = model(op, fw, mw);
      run_instr(op, fw, mw, s);
      compare_all($sformatf("r%0d", i), s, m);
      exp_instret += m.retired;
      check_instret($sformatf("r%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
